timer555_clkgen: RTL

TIMER555_CLKGEN -- requirements
Module: timer555_clkgen

---
 rtl/timer555_clkgen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/timer555_clkgen.sv
// timer555_clkgen: digital stand-in for a 555 timer. Generates a free-running
// clock (astable) or a single pulse (monostable). HIGH and LOW phase lengths
// come from shadow registers. New lengths are staged and only take effect at
// a phase boundary, so a running waveform is never distorted mid-period.
module timer555_clkgen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             enable,
  input  logic             mode,
  input  logic             trig,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic             load,
  output logic             clk_out,
  output logic             busy,
  output logic             period_tick,
  output logic             pulse_done,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
  } cfg_t;

  state_t           state;
  cfg_t             sh;        // active phase lengths
  cfg_t             pend;      // staged lengths waiting for a phase boundary
  logic             pend_vld;
  cfg_t             load_cfg;  // live inputs with zero fields forced to 1
  cfg_t             apply_cfg; // what a phase boundary adopts this cycle
  logic             load_zero;
  logic             trig_q;
  logic             run_mono;  // mode latched when the run started
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             start_ast;
  logic             start_mono;

  // Sanitize incoming lengths and pick the config a boundary would adopt.
  // A load on the same edge as a boundary wins over any older staged value.
  always_comb begin
    load_cfg.hi = high_cnt;
    load_cfg.lo = low_cnt;
    load_zero   = 1'b0;
    if (high_cnt == ZERO) begin
      load_cfg.hi = ONE;
      load_zero   = 1'b1;
    end
    if (low_cnt == ZERO) begin
      load_cfg.lo = ONE;
      load_zero   = 1'b1;
    end
    apply_cfg = sh;
    if (load)
      apply_cfg = load_cfg;
    else if (pend_vld)
      apply_cfg = pend;
  end

  // Start conditions are only evaluated in IDLE, which is where mode is sampled.
  always_comb begin
    cnt_done   = (cnt == ZERO);
    start_ast  = (state == IDLE) && enable && !mode;
    start_mono = (state == IDLE) && enable && mode && trig && !trig_q;
  end

  // Main FSM: phase sequencing, config staging and all registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= IDLE;
      sh.hi       <= ONE;
      sh.lo       <= ONE;
      pend.hi     <= ONE;
      pend.lo     <= ONE;
      pend_vld    <= 1'b0;
      trig_q      <= 1'b0;
      run_mono    <= 1'b0;
      cnt         <= ZERO;
      clk_out     <= 1'b0;
      busy        <= 1'b0;
      period_tick <= 1'b0;
      pulse_done  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      trig_q      <= trig;
      period_tick <= 1'b0;
      pulse_done  <= 1'b0;
      if (load)
        cfg_err <= load_zero;

      case (state)
        IDLE: begin
          if (load)
            sh <= load_cfg;
          pend_vld <= 1'b0;
          if (start_ast || start_mono) begin
            state       <= HIGH;
            run_mono    <= start_mono;
            cnt         <= apply_cfg.hi - ONE;
            clk_out     <= 1'b1;
            busy        <= 1'b1;
            period_tick <= start_ast;
          end
        end

        HIGH: begin
          if (load) begin
            pend     <= load_cfg;
            pend_vld <= 1'b1;
          end
          if (!cnt_done) begin
            cnt <= cnt - ONE;
          end else if (run_mono) begin
            // One-shot ends: adopt any staged config, flag completion.
            state      <= IDLE;
            sh         <= apply_cfg;
            pend_vld   <= 1'b0;
            clk_out    <= 1'b0;
            busy       <= 1'b0;
            pulse_done <= 1'b1;
          end else begin
            // Astable keeps the current LOW length; staging waits for LOW end.
            state   <= LOW;
            cnt     <= sh.lo - ONE;
            clk_out <= 1'b0;
          end
        end

        LOW: begin
          if (load) begin
            pend     <= load_cfg;
            pend_vld <= 1'b1;
          end
          if (!cnt_done) begin
            cnt <= cnt - ONE;
          end else begin
            sh       <= apply_cfg;
            pend_vld <= 1'b0;
            if (enable) begin
              state       <= HIGH;
              cnt         <= apply_cfg.hi - ONE;
              clk_out     <= 1'b1;
              period_tick <= 1'b1;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
              clk_out <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
